aes_key_sched_ctrl: RTL and testbench

//  Sequences the AES-256 key expander and schedules round-key selection for the cipher core.
//  - Accepts a new 256-bit key via valid/ready and pulses the expander start.
//  - Waits for expander done, then serves round-key indices 0..14 (encrypt) or 14..0 (decrypt), one per advance.
//  - Blocks key changes while a block is in flight; blocks new cipher blocks while expanding.

---
 rtl/aes_key_sched_ctrl_if.sv | 33 +++
 rtl/aes_key_sched_ctrl.sv | 151 +++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_ctrl_if.sv
// Handshake bundle between the AES-256 key-schedule controller and its neighbours
// (key source, key expander, cipher core). The controller takes the slave view.
interface aes_key_sched_ctrl_if;
    logic         key_valid;
    logic [255:0] key_data;
    logic         key_ready;
    logic         exp_start;
    logic [255:0] exp_key;
    logic         exp_done;
    logic         blk_valid;
    logic         blk_decrypt;
    logic         blk_ready;
    logic         rk_advance;
    logic [3:0]   rk_sel;
    logic         rk_valid;
    logic         rk_first;
    logic         rk_last;
    logic         blk_done;
    logic         key_loaded;
    logic         exp_err;

    modport master (
        output key_valid, key_data, exp_done, blk_valid, blk_decrypt, rk_advance,
        input  key_ready, exp_start, exp_key, blk_ready, rk_sel, rk_valid,
               rk_first, rk_last, blk_done, key_loaded, exp_err
    );

    modport slave (
        input  key_valid, key_data, exp_done, blk_valid, blk_decrypt, rk_advance,
        output key_ready, exp_start, exp_key, blk_ready, rk_sel, rk_valid,
               rk_first, rk_last, blk_done, key_loaded, exp_err
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES-256 key-schedule controller: loads a key into the expander, supervises expansion
// with a timeout, then walks round-key indices forward (encrypt) or backward (decrypt).
module aes_key_sched_ctrl #(
    parameter int NUM_RK  = 15,
    parameter int EXP_TMO = 31
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_key_sched_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_NOKEY  = 2'd0,
        ST_EXPAND = 2'd1,
        ST_READY  = 2'd2,
        ST_RUN    = 2'd3
    } state_e;

    localparam logic [3:0] RK_MAX  = 4'(NUM_RK - 1);
    localparam logic [4:0] TMO_CNT = 5'(EXP_TMO);

    state_e         state_q,      state_d;
    logic [255:0]   exp_key_q,    exp_key_d;
    logic           exp_start_q,  exp_start_d;
    logic           key_loaded_q, key_loaded_d;
    logic           exp_err_q,    exp_err_d;
    logic [4:0]     tmo_cnt_q,    tmo_cnt_d;
    logic           dir_q,        dir_d;
    logic [3:0]     rk_sel_q,     rk_sel_d;
    logic           rk_valid_q,   rk_valid_d;
    logic           rk_first_q,   rk_first_d;
    logic           blk_done_q,   blk_done_d;

    logic key_ready;
    logic blk_ready;
    logic key_acc;
    logic blk_acc;
    logic rk_last;
    logic rk_step;

    // A pending key starves block acceptance so a new key never waits behind a block.
    assign key_ready = (state_q == ST_NOKEY) || (state_q == ST_READY);
    assign blk_ready = (state_q == ST_READY) && !bus.key_valid;
    assign key_acc   = bus.key_valid && key_ready;
    assign blk_acc   = bus.blk_valid && blk_ready;
    assign rk_last   = rk_valid_q && (dir_q ? (rk_sel_q == 4'd0) : (rk_sel_q == RK_MAX));
    assign rk_step   = bus.rk_advance && rk_valid_q;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        exp_key_d    = exp_key_q;
        exp_start_d  = 1'b0;
        key_loaded_d = key_loaded_q;
        exp_err_d    = exp_err_q;
        tmo_cnt_d    = tmo_cnt_q;
        dir_d        = dir_q;
        rk_sel_d     = rk_sel_q;
        rk_valid_d   = rk_valid_q;
        rk_first_d   = rk_first_q;
        blk_done_d   = 1'b0;

        unique case (state_q)
            ST_NOKEY, ST_READY: begin
                if (key_acc) begin
                    exp_key_d    = bus.key_data;
                    exp_start_d  = 1'b1;
                    key_loaded_d = 1'b0;
                    exp_err_d    = 1'b0;
                    tmo_cnt_d    = 5'd0;
                    state_d      = ST_EXPAND;
                end else if (blk_acc) begin
                    dir_d      = bus.blk_decrypt;
                    rk_sel_d   = bus.blk_decrypt ? RK_MAX : 4'd0;
                    rk_valid_d = 1'b1;
                    rk_first_d = 1'b1;
                    state_d    = ST_RUN;
                end
            end

            ST_EXPAND: begin
                if (bus.exp_done) begin
                    key_loaded_d = 1'b1;
                    state_d      = ST_READY;
                end else if (tmo_cnt_q == TMO_CNT) begin
                    exp_err_d = 1'b1;
                    state_d   = ST_NOKEY;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 5'd1;
                end
            end

            ST_RUN: begin
                if (rk_step) begin
                    rk_first_d = 1'b0;
                    if (rk_last) begin
                        blk_done_d = 1'b1;
                        rk_valid_d = 1'b0;
                        state_d    = ST_READY;
                    end else begin
                        rk_sel_d = dir_q ? (rk_sel_q - 4'd1) : (rk_sel_q + 4'd1);
                    end
                end
            end

            default: state_d = ST_NOKEY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_NOKEY;
            exp_key_q    <= '0;
            exp_start_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            exp_err_q    <= 1'b0;
            tmo_cnt_q    <= 5'd0;
            dir_q        <= 1'b0;
            rk_sel_q     <= 4'd0;
            rk_valid_q   <= 1'b0;
            rk_first_q   <= 1'b0;
            blk_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_key_q    <= exp_key_d;
            exp_start_q  <= exp_start_d;
            key_loaded_q <= key_loaded_d;
            exp_err_q    <= exp_err_d;
            tmo_cnt_q    <= tmo_cnt_d;
            dir_q        <= dir_d;
            rk_sel_q     <= rk_sel_d;
            rk_valid_q   <= rk_valid_d;
            rk_first_q   <= rk_first_d;
            blk_done_q   <= blk_done_d;
        end
    end

    assign bus.key_ready  = key_ready;
    assign bus.exp_start  = exp_start_q;
    assign bus.exp_key    = exp_key_q;
    assign bus.blk_ready  = blk_ready;
    assign bus.rk_sel     = rk_sel_q;
    assign bus.rk_valid   = rk_valid_q;
    assign bus.rk_first   = rk_first_q;
    assign bus.rk_last    = rk_last;
    assign bus.blk_done   = blk_done_q;
    assign bus.key_loaded = key_loaded_q;
    assign bus.exp_err    = exp_err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: key load, encrypt/decrypt walks, key hold-off,
// expander timeout and reset during a block.
module tb_aes_key_sched_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    aes_key_sched_ctrl_if bus ();

    aes_key_sched_ctrl #(.NUM_RK(15), .EXP_TMO(31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [255:0] KEY1 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY2 =
        256'hdeadbeef00112233445566778899aabbccddeeff0123456789abcdeffedcba98;
    localparam logic [255:0] KEY3 =
        256'h1111111122222222333333334444444455555555666666667777777788888888;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 ns after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.key_valid = 1'b0; bus.key_data = '0; bus.exp_done = 1'b0;
        bus.blk_valid = 1'b0; bus.blk_decrypt = 1'b0; bus.rk_advance = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        #1;
        total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL reset_key_ready: got %b want 1", bus.key_ready); end
        total++; if (bus.blk_ready !== 1'b0) begin bad++; $display("FAIL reset_blk_ready: got %b want 0", bus.blk_ready); end
        total++; if (bus.exp_start !== 1'b0) begin bad++; $display("FAIL reset_exp_start: got %b want 0", bus.exp_start); end
        total++; if (bus.exp_key !== 256'd0) begin bad++; $display("FAIL reset_exp_key: got %h want 0", bus.exp_key); end
        total++; if (bus.rk_valid !== 1'b0) begin bad++; $display("FAIL reset_rk_valid: got %b want 0", bus.rk_valid); end
        total++; if (bus.key_loaded !== 1'b0) begin bad++; $display("FAIL reset_key_loaded: got %b want 0", bus.key_loaded); end
        total++; if (bus.exp_err !== 1'b0) begin bad++; $display("FAIL reset_exp_err: got %b want 0", bus.exp_err); end
        total++; if (bus.blk_done !== 1'b0) begin bad++; $display("FAIL reset_blk_done: got %b want 0", bus.blk_done); end
    endtask

    task automatic test_key_load();
        bus.blk_valid = 1'b1;
        #1;
        total++; if (bus.blk_ready !== 1'b0) begin bad++; $display("FAIL nokey_blk_ready: got %b want 0", bus.blk_ready); end
        bus.blk_valid = 1'b0;
        bus.key_valid = 1'b1; bus.key_data = KEY1;
        #1;
        total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL load_key_ready: got %b want 1", bus.key_ready); end
        cyc();
        bus.key_valid = 1'b0; bus.key_data = '0;
        total++; if (bus.exp_start !== 1'b1) begin bad++; $display("FAIL load_exp_start: got %b want 1", bus.exp_start); end
        total++; if (bus.exp_key !== KEY1) begin bad++; $display("FAIL load_exp_key: got %h want %h", bus.exp_key, KEY1); end
        total++; if (bus.key_ready !== 1'b0) begin bad++; $display("FAIL load_key_ready_expand: got %b want 0", bus.key_ready); end
        cyc();
        total++; if (bus.exp_start !== 1'b0) begin bad++; $display("FAIL load_exp_start_pulse: got %b want 0", bus.exp_start); end
        total++; if (bus.exp_key !== KEY1) begin bad++; $display("FAIL load_exp_key_hold: got %h want %h", bus.exp_key, KEY1); end
    endtask

    // Entered one cycle after the exp_start cycle.
    task automatic test_encrypt();
        repeat (13) cyc();
        total++; if (bus.key_loaded !== 1'b0) begin bad++; $display("FAIL enc_not_loaded: got %b want 0", bus.key_loaded); end
        bus.blk_valid = 1'b1;
        #1;
        total++; if (bus.blk_ready !== 1'b0) begin bad++; $display("FAIL enc_expand_blk_ready: got %b want 0", bus.blk_ready); end
        bus.blk_valid = 1'b0;
        bus.exp_done = 1'b1;
        cyc();
        bus.exp_done = 1'b0;
        total++; if (bus.key_loaded !== 1'b1) begin bad++; $display("FAIL enc_key_loaded: got %b want 1", bus.key_loaded); end
        total++; if (bus.blk_ready !== 1'b1) begin bad++; $display("FAIL enc_blk_ready: got %b want 1", bus.blk_ready); end
        bus.blk_valid = 1'b1; bus.blk_decrypt = 1'b0;
        cyc();
        bus.blk_valid = 1'b0;
        total++; if (bus.rk_valid !== 1'b1) begin bad++; $display("FAIL enc_rk_valid: got %b want 1", bus.rk_valid); end
        bus.rk_advance = 1'b1;
        for (int i = 0; i < 15; i++) begin
            total++; if (bus.rk_sel !== 4'(i)) begin bad++; $display("FAIL enc_rk_sel[%0d]: got %0d want %0d", i, bus.rk_sel, i); end
            total++; if (bus.rk_first !== (i == 0)) begin bad++; $display("FAIL enc_rk_first[%0d]: got %b want %b", i, bus.rk_first, (i == 0)); end
            total++; if (bus.rk_last !== (i == 14)) begin bad++; $display("FAIL enc_rk_last[%0d]: got %b want %b", i, bus.rk_last, (i == 14)); end
            total++; if (bus.blk_done !== 1'b0) begin bad++; $display("FAIL enc_blk_done_early[%0d]: got %b want 0", i, bus.blk_done); end
            cyc();
        end
        bus.rk_advance = 1'b0;
        total++; if (bus.blk_done !== 1'b1) begin bad++; $display("FAIL enc_blk_done: got %b want 1", bus.blk_done); end
        total++; if (bus.rk_valid !== 1'b0) begin bad++; $display("FAIL enc_rk_valid_end: got %b want 0", bus.rk_valid); end
        cyc();
        total++; if (bus.blk_done !== 1'b0) begin bad++; $display("FAIL enc_blk_done_pulse: got %b want 0", bus.blk_done); end
        total++; if (bus.blk_ready !== 1'b1) begin bad++; $display("FAIL enc_back_ready: got %b want 1", bus.blk_ready); end
    endtask

    // Advance on every other cycle, starting on the first key cycle: done 29 cycles later.
    task automatic test_decrypt();
        bus.blk_valid = 1'b1; bus.blk_decrypt = 1'b1;
        cyc();
        bus.blk_valid = 1'b0; bus.blk_decrypt = 1'b0;
        for (int s = 14; s >= 0; s--) begin
            total++; if (bus.rk_sel !== 4'(s)) begin bad++; $display("FAIL dec_rk_sel[%0d]: got %0d want %0d", s, bus.rk_sel, s); end
            total++; if (bus.rk_first !== (s == 14)) begin bad++; $display("FAIL dec_rk_first[%0d]: got %b want %b", s, bus.rk_first, (s == 14)); end
            total++; if (bus.rk_last !== (s == 0)) begin bad++; $display("FAIL dec_rk_last[%0d]: got %b want %b", s, bus.rk_last, (s == 0)); end
            total++; if (bus.blk_done !== 1'b0) begin bad++; $display("FAIL dec_blk_done_early[%0d]: got %b want 0", s, bus.blk_done); end
            bus.rk_advance = 1'b1;
            cyc();
            bus.rk_advance = 1'b0;
            if (s > 0) cyc();
        end
        total++; if (bus.blk_done !== 1'b1) begin bad++; $display("FAIL dec_blk_done: got %b want 1", bus.blk_done); end
        total++; if (bus.rk_valid !== 1'b0) begin bad++; $display("FAIL dec_rk_valid_end: got %b want 0", bus.rk_valid); end
        cyc();
        total++; if (bus.blk_ready !== 1'b1) begin bad++; $display("FAIL dec_back_ready: got %b want 1", bus.blk_ready); end
    endtask

    task automatic test_key_hold();
        bus.blk_valid = 1'b1; bus.blk_decrypt = 1'b0;
        cyc();
        bus.blk_valid = 1'b0;
        bus.rk_advance = 1'b1;
        repeat (7) cyc();
        total++; if (bus.rk_sel !== 4'd7) begin bad++; $display("FAIL hold_rk_sel7: got %0d want 7", bus.rk_sel); end
        bus.key_valid = 1'b1; bus.key_data = KEY2;
        for (int i = 7; i < 15; i++) begin
            #1;
            total++; if (bus.key_ready !== 1'b0) begin bad++; $display("FAIL hold_key_ready[%0d]: got %b want 0", i, bus.key_ready); end
            cyc();
        end
        bus.rk_advance = 1'b0;
        total++; if (bus.blk_done !== 1'b1) begin bad++; $display("FAIL hold_blk_done: got %b want 1", bus.blk_done); end
        total++; if (bus.exp_key !== KEY1) begin bad++; $display("FAIL hold_exp_key_unchanged: got %h want %h", bus.exp_key, KEY1); end
        bus.blk_valid = 1'b1;
        #1;
        total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL hold_key_ready_after: got %b want 1", bus.key_ready); end
        total++; if (bus.blk_ready !== 1'b0) begin bad++; $display("FAIL hold_key_wins: got %b want 0", bus.blk_ready); end
        cyc();
        bus.key_valid = 1'b0; bus.blk_valid = 1'b0; bus.key_data = '0;
        total++; if (bus.exp_start !== 1'b1) begin bad++; $display("FAIL hold_exp_start: got %b want 1", bus.exp_start); end
        total++; if (bus.exp_key !== KEY2) begin bad++; $display("FAIL hold_exp_key: got %h want %h", bus.exp_key, KEY2); end
        total++; if (bus.rk_valid !== 1'b0) begin bad++; $display("FAIL hold_no_block: got %b want 0", bus.rk_valid); end
        total++; if (bus.key_loaded !== 1'b0) begin bad++; $display("FAIL hold_key_unloaded: got %b want 0", bus.key_loaded); end
        bus.exp_done = 1'b1;
        cyc();
        bus.exp_done = 1'b0;
        total++; if (bus.key_loaded !== 1'b1) begin bad++; $display("FAIL hold_key_loaded: got %b want 1", bus.key_loaded); end
    endtask

    // Counter is 0 on the exp_start cycle; with no done by count 31 the error lands next edge.
    task automatic test_timeout();
        bus.key_valid = 1'b1; bus.key_data = KEY3;
        cyc();
        bus.key_valid = 1'b0;
        repeat (31) cyc();
        total++; if (bus.exp_err !== 1'b0) begin bad++; $display("FAIL tmo_err_early: got %b want 0", bus.exp_err); end
        total++; if (bus.key_ready !== 1'b0) begin bad++; $display("FAIL tmo_still_expand: got %b want 0", bus.key_ready); end
        cyc();
        total++; if (bus.exp_err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", bus.exp_err); end
        total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL tmo_nokey: got %b want 1", bus.key_ready); end
        total++; if (bus.key_loaded !== 1'b0) begin bad++; $display("FAIL tmo_key_loaded: got %b want 0", bus.key_loaded); end
        bus.blk_valid = 1'b1;
        #1;
        total++; if (bus.blk_ready !== 1'b0) begin bad++; $display("FAIL tmo_blk_ready: got %b want 0", bus.blk_ready); end
        bus.blk_valid = 1'b0;
        bus.exp_done = 1'b1;
        cyc();
        bus.exp_done = 1'b0;
        total++; if (bus.key_loaded !== 1'b0) begin bad++; $display("FAIL tmo_stray_done: got %b want 0", bus.key_loaded); end
        total++; if (bus.exp_err !== 1'b1) begin bad++; $display("FAIL tmo_err_sticky: got %b want 1", bus.exp_err); end
        bus.key_valid = 1'b1; bus.key_data = KEY1;
        cyc();
        bus.key_valid = 1'b0;
        total++; if (bus.exp_err !== 1'b0) begin bad++; $display("FAIL tmo_err_clear: got %b want 0", bus.exp_err); end
        total++; if (bus.exp_start !== 1'b1) begin bad++; $display("FAIL tmo_restart: got %b want 1", bus.exp_start); end
        bus.exp_done = 1'b1;
        cyc();
        bus.exp_done = 1'b0;
        total++; if (bus.key_loaded !== 1'b1) begin bad++; $display("FAIL tmo_reload: got %b want 1", bus.key_loaded); end
    endtask

    task automatic test_reset_mid_run();
        bus.blk_valid = 1'b1; bus.blk_decrypt = 1'b0;
        cyc();
        bus.blk_valid = 1'b0;
        bus.rk_advance = 1'b1;
        repeat (5) cyc();
        total++; if (bus.rk_sel !== 4'd5) begin bad++; $display("FAIL rst_rk_sel5: got %0d want 5", bus.rk_sel); end
        rst_n = 1'b0;
        cyc();
        bus.rk_advance = 1'b0;
        total++; if (bus.rk_valid !== 1'b0) begin bad++; $display("FAIL rst_rk_valid: got %b want 0", bus.rk_valid); end
        total++; if (bus.key_loaded !== 1'b0) begin bad++; $display("FAIL rst_key_loaded: got %b want 0", bus.key_loaded); end
        total++; if (bus.blk_done !== 1'b0) begin bad++; $display("FAIL rst_blk_done: got %b want 0", bus.blk_done); end
        total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL rst_key_ready: got %b want 1", bus.key_ready); end
        rst_n = 1'b1;
        cyc();
        total++; if (bus.blk_done !== 1'b0) begin bad++; $display("FAIL rst_blk_done_after: got %b want 0", bus.blk_done); end
        total++; if (bus.exp_key !== 256'd0) begin bad++; $display("FAIL rst_exp_key: got %h want 0", bus.exp_key); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_key_load();
        test_encrypt();
        test_decrypt();
        test_key_hold();
        test_timeout();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
